rda_iter_adder: RTL
===================

// Module: rda_iter_adder
// PURPOSE
//  Iterative recursive-doubling adder built around the k/p/g carry-status stage.
//  - Accepts one A+B+cin operation per valid/ready handshake.
//  - Generates the per-bit k/p/g status vector.
//  - Resolves carries by applying one doubling level per clock over log2(WIDTH) cycles.
//  - Forms sum/cout and holds them behind an output valid/ready handshake.
//  - Sits between the operand source and the result consumer in the LAB 5 datapath.
// PARAMETERS
//  WIDTH   32  operand width; must be a power of two (>=2)
//  LEVELS  $clog2(WIDTH)  localparam, number of doubling levels (5 for WIDTH=32)
// PORTS
//  clk        in   1            single clock, rising edge
//  rst        in   1            asynchronous, active-high reset
//  in_valid   in   1            operands a/b/cin valid
//  in_ready   out  1            block can accept operands (= state==IDLE && !rst)
//  a          in   WIDTH        operand A
//  b          in   WIDTH        operand B
//  cin        in   1            carry in
//  out_valid  out  1            sum/cout valid
//  out_ready  in   1            consumer accepts result
//  sum        out  WIDTH        registered A+B+cin, low WIDTH bits
//  cout       out  1            registered carry out
//  kgp_o      out  [WIDTH-1:0][7:0]  live status register, ASCII "k"/"p"/"g" per bit
// BEHAVIOUR
//  - Reset (async, any state): state=IDLE, level counter=0, out_valid=0, sum=0,
//    cout=0, status reg all "k", operand regs 0. In-flight operation discarded.
//  - States: IDLE -> LEVEL -> DONE -> IDLE.
//  - IDLE: in_ready=1. On in_valid&&in_ready edge, latch a/b/cin and load status:
//    bit i = "g" if a[i]&b[i]; "k" if ~a[i]&~b[i]; else "p".
//    Bit 0 folded with cin: a "p" at bit 0 loads "g" if cin else "k".
//    Level counter j=0; go to LEVEL.
//  - in_valid outside IDLE is ignored (no accept, no side effect).
//  - LEVEL: each edge applies level j to all bits simultaneously from the old vector:
//    - i>=2^j and s[i]=="p": s[i] <= s[i-2^j].
//    - otherwise s[i] unchanged ("k"/"g" absorb; bits below 2^j untouched).
//    After applying j=LEVELS-1, the edge also registers sum/cout, sets out_valid=1,
//    and goes to DONE. Otherwise j <= j+1.
//  - Carry/sum rules (from the resolved vector, where every entry is "k" or "g"):
//    - c[0]=cin; c[i] = (s[i-1]=="g").
//    - sum[i] = a[i]^b[i]^c[i].
//    - cout = (s[WIDTH-1]=="g").
//  - Latency: accept edge E0; levels applied on E1..E5 (WIDTH=32).
//    out_valid is high from E5 onward.
//  - DONE: out_valid=1; sum, cout and kgp_o held stable while !out_ready.
//    On out_valid&&out_ready edge: out_valid<=0, state IDLE; in_ready=1 next cycle.
//    sum/cout retain their last value after the handshake.
//  - No same-cycle output-handshake + input-accept.
//    Throughput: one add per LEVELS+2 cycles minimum.
//  - Status encoding: 8-bit ASCII "k"/"p"/"g", matching the level stage.
//    No other code value is ever stored.
// TESTING
//  1 a=FFFFFFFF b=0 cin=1 -> sum=00000000 cout=1; out_valid rises exactly 5 edges after accept.
//  2 a=12345678 b=9ABCDEF0 cin=0 -> sum=ACF13568 cout=0.
//  3 a=80000000 b=80000000 cin=0 -> sum=0 cout=1; in DONE kgp_o[31]="g", kgp_o[30:0]="k".
//  4 out_ready low 10 cycles in DONE -> out_valid/sum/cout stable, in_ready=0,
//    a pulsed in_valid is ignored; then one handshake -> IDLE, in_ready=1.
//  5 rst asserted during LEVEL at j=2 -> out_valid=0, sum=0 immediately (async);
//    after release, in_ready=1 and the next add (1+1, cin=0 -> 2) is correct.
//  6 1000 random a/b/cin with random out_ready stalls -> {cout,sum}==a+b+cin every result.

Source files
------------

// File: rtl/rda_iter_adder.sv
// rda_iter_adder: iterative recursive-doubling adder.
// One k/p/g doubling level per clock, result held behind valid/ready.
module rda_iter_adder #(
  parameter int WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WIDTH-1:0]      a,
  input  logic [WIDTH-1:0]      b,
  input  logic                  cin,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WIDTH-1:0]      sum,
  output logic                  cout,
  output logic [WIDTH-1:0][7:0] kgp_o
);

  localparam int LEVELS = $clog2(WIDTH);
  localparam int CW     = (LEVELS > 1) ? $clog2(LEVELS + 1) : 1;

  localparam logic [CW-1:0] LAST = CW'(LEVELS - 1);

  localparam logic [7:0] ST_K = 8'h6b;
  localparam logic [7:0] ST_P = 8'h70;
  localparam logic [7:0] ST_G = 8'h67;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LEVEL,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [CW-1:0]         r_lvl;
  logic [WIDTH-1:0]      r_a;
  logic [WIDTH-1:0]      r_b;
  logic                  r_cin;
  logic [WIDTH-1:0][7:0] r_kgp;
  logic [WIDTH-1:0]      r_sum;
  logic                  r_cout;
  logic                  r_out_valid;

  logic                  w_acc;
  logic                  w_last;
  logic                  w_hs;
  logic [WIDTH-1:0][7:0] w_kgp_ld;
  logic [WIDTH-1:0][7:0] w_kgp_lvl;
  logic [WIDTH-1:0]      w_c;
  logic [WIDTH-1:0]      w_sum;
  logic                  w_cout;

  assign in_ready  = (r_state == S_IDLE) && !rst;
  assign out_valid = r_out_valid;
  assign sum       = r_sum;
  assign cout      = r_cout;
  assign kgp_o     = r_kgp;

  assign w_acc  = in_valid && in_ready;
  assign w_last = (r_state == S_LEVEL) && (r_lvl == LAST);
  assign w_hs   = (r_state == S_DONE) && out_ready;

  // Initial k/p/g vector; carry-in resolves a propagate at bit 0
  always_comb begin
    w_kgp_ld = '0;
    if (a[0] ^ b[0]) begin
      w_kgp_ld[0] = cin ? ST_G : ST_K;
    end else begin
      w_kgp_ld[0] = a[0] ? ST_G : ST_K;
    end
    for (int i = 1; i < WIDTH; i++) begin
      if (a[i] && b[i]) begin
        w_kgp_ld[i] = ST_G;
      end else if (!a[i] && !b[i]) begin
        w_kgp_ld[i] = ST_K;
      end else begin
        w_kgp_ld[i] = ST_P;
      end
    end
  end

  // One doubling level: a "p" inherits status from 2^j bits below
  always_comb begin
    w_kgp_lvl = r_kgp;
    for (int l = 0; l < LEVELS; l++) begin
      if (r_lvl == CW'(l)) begin
        for (int i = (1 << l); i < WIDTH; i++) begin
          if (r_kgp[i] == ST_P) begin
            w_kgp_lvl[i] = r_kgp[i - (1 << l)];
          end
        end
      end
    end
  end

  // Carries from the fully resolved vector
  always_comb begin
    w_c    = '0;
    w_c[0] = r_cin;
    for (int i = 1; i < WIDTH; i++) begin
      w_c[i] = (w_kgp_lvl[i-1] == ST_G);
    end
  end

  assign w_sum  = r_a ^ r_b ^ w_c;
  assign w_cout = (w_kgp_lvl[WIDTH-1] == ST_G);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state: accept, walk levels, hold until consumed
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:  if (w_acc) w_state_nxt = S_LEVEL;
      S_LEVEL: if (w_last) w_state_nxt = S_DONE;
      S_DONE:  if (out_ready) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Datapath: operand latch, level updates, result register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_lvl       <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_cin       <= 1'b0;
      r_kgp       <= {WIDTH{ST_K}};
      r_sum       <= '0;
      r_cout      <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      if (w_acc) begin
        r_a   <= a;
        r_b   <= b;
        r_cin <= cin;
        r_kgp <= w_kgp_ld;
        r_lvl <= '0;
      end
      if (r_state == S_LEVEL) begin
        r_kgp <= w_kgp_lvl;
        if (w_last) begin
          r_sum       <= w_sum;
          r_cout      <= w_cout;
          r_out_valid <= 1'b1;
        end else begin
          r_lvl <= r_lvl + CW'(1);
        end
      end
      if (w_hs) begin
        r_out_valid <= 1'b0;
      end
    end
  end

endmodule
